// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and BCD constants for the stopwatch slice
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] BCD_MAX  = 4'd9;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - one-bit rising-edge detector on an already synchronised level
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
        end else begin
            prev <= btn;
        end
    end

    // Combinational so the action lands on the same edge that samples the level.
    assign rise = btn & ~prev;

endmodule

// File: rtl/stopwatch.sv
// rtl/stopwatch.sv - single BCD digit datapath counted by cnt_en, cleared by cnt_clr
module stopwatch
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cnt_en,
    input  logic       cnt_clr,
    output logic [3:0] d,
    output logic       max_tick
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d <= 4'd0;
        end else if (cnt_clr) begin
            d <= 4'd0;
        end else if (cnt_en) begin
            d <= (d == BCD_MAX) ? 4'd0 : d + 4'd1;
        end
    end

    assign max_tick = (d == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap/clear sequencer and prescaler for the stopwatch datapath
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV         = 4,
    parameter bit          STOP_AT_MAX = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic [3:0] d,
    input  logic       max_tick,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       running,
    output logic [3:0] lap_d,
    output logic       lap_valid,
    output logic       overflow
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic          start_e, lap_e, clear_e;
    logic [1:0]    state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          slot_end, term, lap_take;

    btn_edge u_start (.clk(clk), .reset(reset), .btn(btn_start), .rise(start_e));
    btn_edge u_lap   (.clk(clk), .reset(reset), .btn(btn_lap),   .rise(lap_e));
    btn_edge u_clear (.clk(clk), .reset(reset), .btn(btn_clear), .rise(clear_e));

    assign slot_end = (state == ST_RUN) && (presc == PRESC_MAX);
    assign term     = slot_end && max_tick;
    // With STOP_AT_MAX the terminal slot is swallowed so the datapath parks on 9.
    assign cnt_en   = slot_end && !(STOP_AT_MAX && max_tick);
    assign running  = (state == ST_RUN);
    assign lap_take = lap_e && !clear_e && !start_e &&
                      ((state == ST_RUN) || (state == ST_PAUSE));

    always_comb begin
        state_nxt = state;
        if (clear_e) begin
            state_nxt = ST_IDLE;
        end else if (term && STOP_AT_MAX) begin
            state_nxt = ST_DONE;
        end else if (start_e) begin
            case (state)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = state;
            endcase
        end
    end

    // The slot in flight completes even when a pause lands on it, so the phase survives.
    always_comb begin
        presc_nxt = presc;
        if (clear_e || (state == ST_IDLE) || (state == ST_DONE)) begin
            presc_nxt = '0;
        end else if (state == ST_RUN) begin
            presc_nxt = (presc == PRESC_MAX) ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            presc     <= '0;
            cnt_clr   <= 1'b0;
            lap_d     <= 4'd0;
            lap_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            cnt_clr <= clear_e;
            if (clear_e) begin
                lap_d     <= 4'd0;
                lap_valid <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (lap_take) begin
                    lap_d     <= d;
                    lap_valid <= 1'b1;
                end
                if (term) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed bench: halting (a) and wrapping (b) controllers on shared buttons
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;

    logic       en_a, clr_a, run_a, lapv_a, ovf_a, mt_a;
    logic [3:0] lapd_a, d_a;
    logic       en_b, clr_b, run_b, lapv_b, ovf_b, mt_b;
    logic [3:0] lapd_b, d_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DIV(4), .STOP_AT_MAX(1'b1)) u_ctrl_a (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .d(d_a), .max_tick(mt_a), .cnt_en(en_a), .cnt_clr(clr_a), .running(run_a),
        .lap_d(lapd_a), .lap_valid(lapv_a), .overflow(ovf_a)
    );
    stopwatch u_dp_a (.clk(clk), .reset(reset), .cnt_en(en_a), .cnt_clr(clr_a), .d(d_a), .max_tick(mt_a));

    stopwatch_ctrl #(.DIV(4), .STOP_AT_MAX(1'b0)) u_ctrl_b (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .d(d_b), .max_tick(mt_b), .cnt_en(en_b), .cnt_clr(clr_b), .running(run_b),
        .lap_d(lapd_b), .lap_valid(lapv_b), .overflow(ovf_b)
    );
    stopwatch u_dp_b (.clk(clk), .reset(reset), .cnt_en(en_b), .cnt_clr(clr_b), .d(d_b), .max_tick(mt_b));

    typedef struct {
        logic s, l, c;
        logic run, en;
        int   d, lapd;
        logic lapv, ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, l, c, run, en, input int dd, lapd,
                                input logic lapv, ovf);
        vec_t v;
        v.s = s; v.l = l; v.c = c; v.run = run; v.en = en;
        v.d = dd; v.lapd = lapd; v.lapv = lapv; v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses_a, pulses_b;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        chk("reset running", run_a, 0);
        chk("reset cnt_en", en_a, 0);
        chk("reset cnt_clr", clr_a, 0);
        chk("reset lap_d", lapd_a, 0);
        chk("reset lap_valid", lapv_a, 0);
        chk("reset overflow", ovf_a, 0);
        chk("reset d", d_a, 0);

        // start, count, pause across 6 cycles, resume on original phase, lap at d=5
        add(1,0,0, 1,0, 0,0,0,0);
        add(1,0,0, 1,0, 0,0,0,0);
        add(0,0,0, 1,0, 0,0,0,0);
        add(0,0,0, 1,1, 0,0,0,0);
        add(0,0,0, 1,0, 1,0,0,0);
        add(0,0,0, 1,0, 1,0,0,0);
        add(0,0,0, 1,0, 1,0,0,0);
        add(0,0,0, 1,1, 1,0,0,0);
        add(0,0,0, 1,0, 2,0,0,0);
        add(1,0,0, 0,0, 2,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0, 0,0, 2,0,0,0);
        add(1,0,0, 1,0, 2,0,0,0);
        add(0,0,0, 1,0, 2,0,0,0);
        add(0,0,0, 1,1, 2,0,0,0);
        add(0,0,0, 1,0, 3,0,0,0);
        add(0,0,0, 1,0, 3,0,0,0);
        add(0,0,0, 1,0, 3,0,0,0);
        add(0,0,0, 1,1, 3,0,0,0);
        add(0,0,0, 1,0, 4,0,0,0);
        add(0,0,0, 1,0, 4,0,0,0);
        add(0,0,0, 1,0, 4,0,0,0);
        add(0,0,0, 1,1, 4,0,0,0);
        add(0,0,0, 1,0, 5,0,0,0);
        add(0,1,0, 1,0, 5,5,1,0);
        add(0,1,0, 1,0, 5,5,1,0);
        add(0,0,0, 1,1, 5,5,1,0);
        add(0,0,0, 1,0, 6,5,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            btn_start = vecs[i].s; btn_lap = vecs[i].l; btn_clear = vecs[i].c;
            step();
            chk($sformatf("v%0d running_a", i), run_a, vecs[i].run);
            chk($sformatf("v%0d cnt_en_a", i), en_a, vecs[i].en);
            chk($sformatf("v%0d d_a", i), d_a, vecs[i].d);
            chk($sformatf("v%0d lap_d_a", i), lapd_a, vecs[i].lapd);
            chk($sformatf("v%0d lap_valid_a", i), lapv_a, vecs[i].lapv);
            chk($sformatf("v%0d overflow_a", i), ovf_a, vecs[i].ovf);
            chk($sformatf("v%0d running_b", i), run_b, vecs[i].run);
            chk($sformatf("v%0d cnt_en_b", i), en_b, vecs[i].en);
            chk($sformatf("v%0d d_b", i), d_b, vecs[i].d);
        end
        btn_start = 0; btn_lap = 0; btn_clear = 0;

        // terminal count: a halts in DONE, b wraps
        repeat (12) step();
        chk("pre-term d_a", d_a, 9);
        chk("pre-term d_b", d_b, 9);
        repeat (3) step();
        chk("term slot cnt_en_a", en_a, 0);
        chk("term slot cnt_en_b", en_b, 1);
        step();
        chk("done running_a", run_a, 0);
        chk("done overflow_a", ovf_a, 1);
        chk("done d_a", d_a, 9);
        chk("done lap_d_a", lapd_a, 5);
        chk("wrap running_b", run_b, 1);
        chk("wrap overflow_b", ovf_b, 1);
        chk("wrap d_b", d_b, 0);
        pulses_a = 0; pulses_b = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            pulses_a += int'(en_a);
            pulses_b += int'(en_b);
        end
        chk("done pulses_a", pulses_a, 0);
        chk("wrap pulses_b", pulses_b, 2);
        chk("wrap d_b after", d_b, 2);

        btn_start = 1; step();
        chk("done ignores start", run_a, 0);
        btn_start = 0; btn_lap = 1; step();
        chk("done ignores lap", lapd_a, 5);
        btn_lap = 0; step();
        chk("done d_a held", d_a, 9);

        // clear from DONE, then lap in IDLE
        btn_clear = 1; step();
        chk("clear cnt_clr_a", clr_a, 1);
        chk("clear cnt_clr_b", clr_b, 1);
        chk("clear cnt_en_a", en_a, 0);
        chk("clear running_a", run_a, 0);
        chk("clear overflow_a", ovf_a, 0);
        chk("clear overflow_b", ovf_b, 0);
        chk("clear lap_valid_a", lapv_a, 0);
        chk("clear lap_d_a", lapd_a, 0);
        btn_clear = 0; step();
        chk("clear pulse width", clr_a, 0);
        chk("cleared d_a", d_a, 0);
        chk("cleared d_b", d_b, 0);
        btn_lap = 1; step();
        chk("idle ignores lap", lapv_a, 0);
        btn_lap = 0; step();

        // clear and start in the same cycle while running
        btn_start = 1; step();
        chk("restart running_a", run_a, 1);
        btn_start = 0; btn_lap = 1; step();
        chk("lap at d=0 valid", lapv_a, 1);
        chk("lap at d=0 value", lapd_a, 0);
        btn_lap = 0; step();
        btn_start = 1; btn_clear = 1; step();
        chk("clr+start running", run_a, 0);
        chk("clr+start cnt_clr", clr_a, 1);
        chk("clr+start cnt_en", en_a, 0);
        chk("clr+start lap_valid", lapv_a, 0);
        chk("clr+start overflow", ovf_a, 0);
        btn_start = 0; btn_clear = 0; step();
        chk("clr+start cnt_clr drop", clr_a, 0);
        chk("clr+start d", d_a, 0);
        repeat (3) step();
        chk("start not deferred", run_a, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
